// File: rtl/reg_share_pkg.sv
// Shared types and default sizing for the round-robin shared-register arbiter.
package reg_share_pkg;

  localparam int unsigned N_REQ_DEF = 4;
  localparam int unsigned DW_DEF    = 8;
  localparam int unsigned HOLD_DEF  = 2;

  // Wide enough for HOLD_CYC up to 15.
  localparam int unsigned CntW = 4;

  typedef enum logic [0:0] {
    StIdle,
    StHold
  } state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr_i, wrapping to 0.
module rr_pick #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned PW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [PW-1:0]    ptr_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [PW-1:0]    idx_o,
  output logic             any_o
);

  int unsigned j;
  logic        found;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    j     = 0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      j = {{(32 - PW){1'b0}}, ptr_i} + k;
      if (j >= N_REQ) j = j - N_REQ;
      if (!found && req_i[j]) begin
        found    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = PW'(j);
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/reg_share_arb.sv
// Shared register written by N_REQ requesters under round-robin arbitration, with a
// fixed lockout of HOLD_CYC cycles after every write.
module reg_share_arb
  import reg_share_pkg::*;
#(
  parameter int unsigned N_REQ    = N_REQ_DEF,
  parameter int unsigned DW       = DW_DEF,
  parameter int unsigned HOLD_CYC = HOLD_DEF
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst_n,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*DW-1:0]      din,
  output logic [N_REQ-1:0]         gnt,
  output logic [$clog2(N_REQ)-1:0] owner,
  output logic [DW-1:0]            q,
  output logic                     busy
);

  localparam int unsigned PW = $clog2(N_REQ);

  state_e            state_q;
  logic [CntW-1:0]   cnt_q;
  logic [PW-1:0]     ptr_q;
  logic [PW-1:0]     owner_q;
  logic [N_REQ-1:0]  gnt_q;
  logic [DW-1:0]     q_q;

  logic [N_REQ-1:0]  win_oh;
  logic [PW-1:0]     win_idx;
  logic              win_any;
  logic [PW-1:0]     ptr_next;

  rr_pick #(
    .N_REQ (N_REQ),
    .PW    (PW)
  ) u_rr_pick (
    .req_i (req),
    .ptr_i (ptr_q),
    .gnt_o (win_oh),
    .idx_o (win_idx),
    .any_o (win_any)
  );

  assign ptr_next = (win_idx == PW'(N_REQ - 1)) ? '0 : win_idx + 1'b1;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      ptr_q   <= '0;
      owner_q <= '0;
      gnt_q   <= '0;
      q_q     <= '0;
    end else begin
      gnt_q <= '0;
      unique case (state_q)
        StIdle: begin
          if (win_any) begin
            gnt_q   <= win_oh;
            q_q     <= din[win_idx*DW +: DW];
            owner_q <= win_idx;
            ptr_q   <= ptr_next;
            cnt_q   <= CntW'(HOLD_CYC - 1);
            state_q <= StHold;
          end
        end
        StHold: begin
          // Requests are ignored here; the lockout lasts cnt_q+1 cycles.
          if (cnt_q == '0) begin
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign gnt   = gnt_q;
  assign owner = owner_q;
  assign q     = q_q;
  assign busy  = (state_q != StIdle);

endmodule

// File: tb/tb_reg_share_arb.sv
// Directed scenarios plus randomized traffic checked against a cycle-level arbitration model.
module tb_reg_share_arb;

  localparam int N = 4;
  localparam int W = 8;
  localparam int H = 2;

  logic             sys_clk = 1'b0;
  logic             sys_rst_n;
  logic [N-1:0]     req;
  logic [N*W-1:0]   din;
  logic [N-1:0]     gnt;
  logic [1:0]       owner;
  logic [W-1:0]     q;
  logic             busy;

  int checks   = 0;
  int failures = 0;

  // Reference model state: m_left counts remaining lockout cycles (0 means idle).
  int           m_ptr;
  int           m_left;
  int           m_owner;
  logic [N-1:0] m_gnt;
  logic [W-1:0] m_q;

  logic [N-1:0] dut_gnts[$];
  int           gnt1_seen;

  reg_share_arb #(
    .N_REQ    (N),
    .DW       (W),
    .HOLD_CYC (H)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .req       (req),
    .din       (din),
    .gnt       (gnt),
    .owner     (owner),
    .q         (q),
    .busy      (busy)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr   = 0;
    m_left  = 0;
    m_owner = 0;
    m_gnt   = '0;
    m_q     = '0;
  endtask

  task automatic model_edge();
    if (!sys_rst_n) begin
      model_reset();
      return;
    end
    m_gnt = '0;
    if (m_left > 0) begin
      m_left--;
    end else if (req != '0) begin
      for (int k = 0; k < N; k++) begin
        int w = (m_ptr + k) % N;
        if (req[w]) begin
          m_gnt[w] = 1'b1;
          m_q      = din[w*W +: W];
          m_owner  = w;
          m_ptr    = (w + 1) % N;
          m_left   = H;
          break;
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".gnt"}, 32'(gnt), 32'(m_gnt));
    chk({tag, ".q"}, 32'(q), 32'(m_q));
    chk({tag, ".owner"}, 32'(owner), m_owner);
    chk({tag, ".busy"}, 32'(busy), 32'(m_left > 0));
  endtask

  task automatic step(input string tag);
    @(posedge sys_clk);
    model_edge();
    #1;
    if (gnt != '0) dut_gnts.push_back(gnt);
    if (gnt[1]) gnt1_seen++;
    check_all(tag);
  endtask

  task automatic pulse_reset();
    sys_rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    chk("async_rst.q0", 32'(q), 32'h0);
    chk("async_rst.busy0", 32'(busy), 32'h0);
    #1;
    sys_rst_n = 1'b1;
  endtask

  initial begin
    // Scenario 1: reset held 20 ns with all requests high.
    sys_rst_n = 1'b0;
    req       = '1;
    din       = 32'h5A3C_9617;
    model_reset();
    #1;
    check_all("s1_t1");
    step("s1_e1");
    step("s1_e2");
    chk("s1.gnt0", 32'(gnt), 32'h0);
    #4;
    req       = '0;
    sys_rst_n = 1'b1;

    // Scenario 2: single request from requester 2.
    @(posedge sys_clk);
    model_edge();
    #1;
    check_all("s2_idle");
    req = 4'b0100;
    din[2*W +: W] = 8'hA5;
    step("s2_grant");
    chk("s2.gnt", 32'(gnt), 32'h4);
    chk("s2.q", 32'(q), 32'hA5);
    chk("s2.owner", 32'(owner), 32'h2);
    req = '0;
    step("s2_hold1");
    chk("s2.busy_h1", 32'(busy), 32'h1);
    step("s2_hold2");
    chk("s2.busy_done", 32'(busy), 32'h0);

    // Scenario 3: all requesting from ptr 0, rotation spaced H+1 cycles.
    pulse_reset();
    req = '1;
    for (int i = 0; i < N; i++) din[i*W +: W] = 8'(8'h10 + i);
    dut_gnts.delete();
    repeat (13) step("s3");
    chk("s3.ngrants", dut_gnts.size(), 5);
    if (dut_gnts.size() >= 5) begin
      chk("s3.g0", 32'(dut_gnts[0]), 32'h1);
      chk("s3.g1", 32'(dut_gnts[1]), 32'h2);
      chk("s3.g2", 32'(dut_gnts[2]), 32'h4);
      chk("s3.g3", 32'(dut_gnts[3]), 32'h8);
      chk("s3.g4", 32'(dut_gnts[4]), 32'h1);
    end
    chk("s3.q_last", 32'(q), 32'h10);
    req = '0;
    repeat (2) step("s3_drain");

    // Scenario 4: grant 3, then 1001 must wrap to 0 before 3 again.
    req = 4'b1000;
    step("s4_g3");
    chk("s4.gnt3", 32'(gnt), 32'h8);
    req = 4'b1001;
    dut_gnts.delete();
    repeat (6) step("s4");
    chk("s4.ngrants", dut_gnts.size(), 2);
    if (dut_gnts.size() >= 2) begin
      chk("s4.first", 32'(dut_gnts[0]), 32'h1);
      chk("s4.second", 32'(dut_gnts[1]), 32'h8);
    end
    req = '0;
    repeat (2) step("s4_drain");

    // Scenario 5: requester 1 asserts only during the lockout.
    gnt1_seen = 0;
    req = 4'b0100;
    step("s5_grant");
    req = 4'b0010;
    repeat (2) step("s5_hold");
    req = '0;
    repeat (3) step("s5_after");
    chk("s5.no_gnt1", gnt1_seen, 0);

    // Scenario 6: reset mid-lockout, then ptr restarts at 0.
    req = 4'b0100;
    step("s6_grant");
    req = '0;
    #2;
    sys_rst_n = 1'b0;
    #1;
    model_reset();
    chk("s6.q", 32'(q), 32'h0);
    chk("s6.busy", 32'(busy), 32'h0);
    chk("s6.gnt", 32'(gnt), 32'h0);
    req = 4'b0010;
    din[1*W +: W] = 8'h3C;
    #2;
    sys_rst_n = 1'b1;
    step("s6_first");
    chk("s6.gnt1", 32'(gnt), 32'h2);
    chk("s6.q1", 32'(q), 32'h3C);
    req = '0;
    repeat (2) step("s6_drain");

    // Randomized traffic with occasional asynchronous resets.
    for (int n = 0; n < 400; n++) begin
      req = N'($urandom);
      din = $urandom;
      if ($urandom_range(49) == 0) pulse_reset();
      step("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_share_arb.md
REG_SHARE_ARB -- requirements
Module: reg_share_arb

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, named sys_clk and sys_rst_n.
REQ-002 Parameter N_REQ, default 4, SHALL set the number of requesters sharing the register (legal range 2..8).
REQ-003 Parameter DW, default 8, SHALL set the shared register width.
REQ-004 Parameter HOLD_CYC, default 2, SHALL set the lockout cycles after each write (legal range 1..15).
REQ-005 sys_clk  input  1  SHALL be the rising-edge clock for all state.
REQ-006 sys_rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-007 req  input  N_REQ  SHALL be the per-requester write request; bit i belongs to requester i.
REQ-008 din  input  N_REQ*DW  SHALL carry the write data; slice i is [i*DW +: DW].
REQ-009 gnt  output  N_REQ  SHALL be a registered one-hot grant, a 1-cycle pulse.
REQ-010 owner  output  clog2(N_REQ)  SHALL give the index of the last granted requester.
REQ-011 q  output  DW  SHALL be the shared register contents.
REQ-012 busy  output  1  SHALL be high whenever the state is not IDLE.

Function
REQ-013 The FSM SHALL have exactly two states: IDLE and HOLD.
REQ-014 In IDLE with req != 0, the next rising edge SHALL do all of the following: set gnt to the one-hot winner, set q to the winner's din slice, set owner to the winner, load the lockout counter with HOLD_CYC-1, and go to HOLD.
REQ-015 In IDLE with req == 0, gnt SHALL stay 0 and q and owner SHALL hold their values.
REQ-016 The winner SHALL be the first set req bit found by searching upward from ptr, wrapping from N_REQ-1 to 0.
REQ-017 After each grant, ptr SHALL become (winner+1) mod N_REQ.
REQ-018 gnt SHALL be high for exactly one cycle, which is the first cycle the new q value is visible.
REQ-019 In HOLD, gnt SHALL be 0, req SHALL be ignored, and the counter SHALL decrement each cycle.
REQ-020 In HOLD, when the counter is 0, the next edge SHALL return the FSM to IDLE; HOLD therefore lasts exactly HOLD_CYC cycles.
REQ-021 The minimum spacing between grants SHALL be HOLD_CYC+1 cycles.
REQ-022 Requesters SHALL hold req and din stable until they see their gnt bit.
REQ-023 A requester whose req stays high after its gnt SHALL be treated as a new request; it wins again only once the round-robin order reaches it.
REQ-024 A req bit that drops before being granted SHALL be forgotten; there SHALL be no request queue.
REQ-025 When a single requester is active, it SHALL be granted every HOLD_CYC+1 cycles.
REQ-026 When all requesters are active, grants SHALL rotate 0,1,...,N_REQ-1,0 with no requester starved.

Reset
REQ-027 Asserting sys_rst_n low SHALL immediately force: state IDLE, gnt 0, q 0, owner 0, ptr 0, counter 0, busy 0.
REQ-028 Reset asserted during HOLD SHALL abort the lockout; q SHALL clear to 0 and no grant SHALL be replayed.
REQ-029 After reset release, the first request SHALL be arbitrable at the first rising edge on which sys_rst_n is high.

Structure
REQ-030 Package reg_share_pkg SHALL hold the state enum (IDLE, HOLD) and the default constants N_REQ_DEF=4, DW_DEF=8, HOLD_DEF=2.
REQ-031 The winner search SHALL be a purely combinational sub-module rr_pick (inputs req and ptr; outputs the one-hot winner, its index, and any_req).
REQ-032 The shared register, the FSM and the counter SHALL live in reg_share_arb.

Verification (N_REQ=4, DW=8, HOLD_CYC=2, 10 ns clock)
REQ-033 Scenario 1: hold sys_rst_n low for 20 ns with req=4'b1111 -> gnt=0, q=8'h00 and busy=0 throughout reset.
REQ-034 Scenario 2: req=4'b0100, din[2]=8'hA5 -> one cycle later gnt=4'b0100, q=8'hA5, owner=2; busy high for 2 cycles.
REQ-035 Scenario 3: req=4'b1111 held, din[i]=8'h10+i -> gnt sequence 0001,0010,0100,1000,0001 spaced 3 cycles apart, with q=8'h10,11,12,13,10.
REQ-036 Scenario 4: after a grant to requester 3, req=4'b1001 -> requester 0 is granted next (wrap), then requester 3.
REQ-037 Scenario 5: req[1] pulses during HOLD only -> no grant is ever issued to requester 1.
REQ-038 Scenario 6: sys_rst_n pulsed low mid-HOLD -> q=0, busy=0 immediately; after release, req=4'b0010 is granted first (ptr=0 search).
